winograd_input_transform_unit: RTL

Computes the Winograd F(4x4,3x3) input-tile transform V = B^T · d · B, mapping a 6x6 signed input tile to a 6x6 transformed tile for the element-wise multiply stage. It sits at the front of the Winograd datapath, ahead of the Hadamard multiplier. It is the forward counterpart of the output (reverse) transform unit. The unit uses one time-shared 6-point 1D transform in two sequential passes: 6 columns, then 6 rows.

---
 rtl/winograd_input_transform_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/winograd_input_transform_unit.sv
// Winograd F(4x4,3x3) input transform V = B^T * d * B.
// One shared 6-point 1D transform runs first over the 6 columns, then over the 6 rows.
module winograd_input_transform_unit #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [IN_W-1:0]  d [0:5][0:5],
    output logic signed [OUT_W-1:0] V [0:5][0:5],
    output logic                    done,
    output logic                    busy
);

    // state   | meaning
    // S_IDLE  | waiting for start, captures d into tile
    // S_PASS1 | column pass, temp column idx <- T(tile column idx)
    // S_PASS2 | row pass, V row idx <- T(temp row idx)
    // S_DONE  | result valid, waits for start to drop
    typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_DONE} state_t;

    state_t                  state;
    logic [2:0]              idx;
    logic signed [IN_W-1:0]  tile [0:5][0:5];
    logic signed [OUT_W-1:0] temp [0:5][0:5];
    logic signed [OUT_W-1:0] x [0:5];
    logic signed [OUT_W-1:0] y [0:5];

    always_comb begin
        for (int k = 0; k < 6; k++) x[k] = '0;
        case (state)
            S_PASS1: for (int k = 0; k < 6; k++)
                         x[k] = {{(OUT_W-IN_W){tile[k][idx][IN_W-1]}}, tile[k][idx]};
            S_PASS2: for (int k = 0; k < 6; k++)
                         x[k] = temp[idx][k];
            default: ;
        endcase
    end

    // Rows of B^T built from shifts and adds only
    always_comb begin
        y[0] = (x[0] <<< 2) - (x[2] <<< 2) - x[2] + x[4];
        y[1] = x[3] + x[4] - (x[1] <<< 2) - (x[2] <<< 2);
        y[2] = (x[1] <<< 2) - (x[2] <<< 2) - x[3] + x[4];
        y[3] = (x[3] <<< 1) + x[4] - (x[1] <<< 1) - x[2];
        y[4] = (x[1] <<< 1) - x[2] - (x[3] <<< 1) + x[4];
        y[5] = (x[1] <<< 2) - (x[3] <<< 2) - x[3] + x[5];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            for (int r = 0; r < 6; r++) begin
                for (int c = 0; c < 6; c++) begin
                    tile[r][c] <= '0;
                    temp[r][c] <= '0;
                    V[r][c]    <= '0;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int r = 0; r < 6; r++)
                            for (int c = 0; c < 6; c++)
                                tile[r][c] <= d[r][c];
                        busy  <= 1'b1;
                        idx   <= '0;
                        state <= S_PASS1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_PASS1: begin
                    for (int k = 0; k < 6; k++) temp[k][idx] <= y[k];
                    if (idx == 3'd5) begin
                        idx   <= '0;
                        state <= S_PASS2;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                S_PASS2: begin
                    for (int k = 0; k < 6; k++) V[idx][k] <= y[k];
                    if (idx == 3'd5) begin
                        idx   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
